metaball_scheduler: RTL and testbench
=====================================

Name: metaball_scheduler

Overview:
Frame sequencer for the lava-lamp metaball field. Once per frame it pulses move-enable to all metaball instances, then raster-scans every display pixel. For each pixel it broadcasts the sample coordinate, strobes all ball dividers, waits for every ball to complete and sums the contributions with saturation. It thresholds the sum and writes one intensity byte per pixel to the framebuffer through a valid/ready port.

Parameters:
N_BALLS, 4, number of metaball instances served (1..16)
DISP_W, 32, display width in pixels
DISP_H, 64, display height in pixels
THRESH, 32'h0001_0000, field threshold in Q16.16 (1.0)
TIMEOUT, 64, max cycles to wait for all ball_vld after a strobe
ADDR_W, $clog2(DISP_W*DISP_H), framebuffer address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
frame_tick  in  1  single-cycle frame request (60 Hz)
mov_en  out  1  one-cycle pulse to all balls: advance position
p_x  out  32  sample x, Q16.16 = pixel_x << 16
p_y  out  32  sample y, Q16.16 = pixel_y << 16
px_stb  out  1  one-cycle start pulse to all ball dividers
ball_vld  in  N_BALLS  per-ball completion flags
ball_out  in  32*N_BALLS  per-ball contribution; ball i at [32*i+31:32*i], unsigned Q16.16
fb_we  out  1  framebuffer write valid
fb_ready  in  1  framebuffer accepts write when high with fb_we
fb_addr  out  ADDR_W  pixel_y*DISP_W + pixel_x
fb_data  out  8  pixel intensity
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the last pixel write is accepted
err  out  2  sticky: [0] ball timeout, [1] frame overrun

Behaviour:
- Reset: all outputs 0; state IDLE; pixel_x=pixel_y=0; sum=0; pending=0; err=0. Reset mid-frame aborts immediately, with no further fb writes.
- States: IDLE, MOVE, STROBE, WAIT, ACCUM, WRITE, DONE.
- IDLE: on frame_tick or pending, clear pending and go to MOVE.
- MOVE: mov_en=1 for exactly 1 cycle, then go to STROBE with pixel (0,0).
- STROBE: p_x/p_y are stable from this cycle until the pixel's WRITE handshake completes. px_stb=1 for 1 cycle; clear the wait counter; go to WAIT.
- WAIT: ball_vld is ignored in the first WAIT cycle because balls drop vld no later than the cycle after px_stb. From the second WAIT cycle, go to ACCUM when &ball_vld.
  - If the counter reaches TIMEOUT first, set err[0] and go to ACCUM.
  - After a timeout, balls with vld=0 contribute 0.
- ACCUM: one ball per cycle, index 0..N_BALLS-1, so N_BALLS cycles. sum = sat32(sum + ball_out[i]), which saturates at 32'hFFFF_FFFF. Then go to WRITE.
- WRITE: fb_we=1, with fb_addr/fb_data held stable until fb_ready.
  - fb_data = 8'hFF if sum >= THRESH, else sum[15:8].
  - When the write is accepted: clear sum and advance the pixel.
  - Pixel advance: x++; at DISP_W-1, x wraps to 0 and y++.
  - After pixel (DISP_W-1, DISP_H-1) is accepted, go to DONE; otherwise go to STROBE.
- DONE: frame_done=1 for 1 cycle; reset pixel counters; go to IDLE.
- frame_tick while busy: if pending=0, set pending=1. If pending is already 1, drop the tick and set err[1].
- frame_tick in the same cycle as the DONE→IDLE transition sets pending, and the next frame starts after one IDLE cycle.
- Per-pixel latency, with all balls completing in L cycles after px_stb and fb_ready high: 1 + max(2,L) + N_BALLS + 1 cycles.
- err bits clear only on rst.

Test Plan:
- DISP_W=4, DISP_H=2, N_BALLS=2, stub balls L=3, ball_out=32'h0000_8000 each; one frame_tick → 1 mov_en, 8 px_stb, 8 writes at addr 0..7 each with fb_data=8'hFF (sum 1.0 ≥ THRESH), frame_done once, err=0.
- Same setup with ball_out=32'h0000_2000 each (sum 0x4000) → fb_data=8'h40 at every address.
- ball_out=32'hFFFF_0000 for both balls → sum saturates to 32'hFFFF_FFFF, fb_data=8'hFF, no wrap to a small value.
- fb_ready held low for 5 cycles on pixel 3 → fb_we, fb_addr=3 and fb_data stable for 5 cycles; no px_stb issued until accepted.
- Ball 1 never asserts vld, TIMEOUT=8 → err[0]=1, ACCUM entered 9 cycles after px_stb, fb_data reflects ball 0 only.
- Three frame_ticks during one frame → second frame runs back-to-back, third dropped, err[1]=1. Separately, rst asserted mid-WAIT → all outputs 0 next cycle and no fb_we afterwards.

Source files
------------

// File: rtl/metaball_scheduler.sv
// Per-frame sequencer for the metaball field: pulses ball movement, then rasters every
// pixel, collects all ball contributions, thresholds the sum and writes one byte per pixel.
module metaball_scheduler #(
  parameter int          N_BALLS = 4,
  parameter int          DISP_W  = 32,
  parameter int          DISP_H  = 64,
  parameter logic [31:0] THRESH  = 32'h0001_0000,
  parameter int          TIMEOUT = 64,
  parameter int          ADDR_W  = $clog2(DISP_W*DISP_H)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  output logic                   mov_en,
  output logic [31:0]            p_x,
  output logic [31:0]            p_y,
  output logic                   px_stb,
  input  logic [N_BALLS-1:0]     ball_vld,
  input  logic [32*N_BALLS-1:0]  ball_out,
  output logic                   fb_we,
  input  logic                   fb_ready,
  output logic [ADDR_W-1:0]      fb_addr,
  output logic [7:0]             fb_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic [1:0]             err
);

  localparam int XW = (DISP_W > 1) ? $clog2(DISP_W) : 1;
  localparam int YW = (DISP_H > 1) ? $clog2(DISP_H) : 1;
  localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_STROBE, S_WAIT, S_ACCUM, S_WRITE, S_DONE
  } state_t;

  state_t              state_q;
  logic [XW-1:0]       px_q;
  logic [YW-1:0]       py_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         sum_q;
  logic [IW-1:0]       idx_q;
  logic [CW-1:0]       cnt_q;
  logic [N_BALLS-1:0]  vld_q;
  logic                pending_q;
  logic                mov_en_q;
  logic                px_stb_q;
  logic                fb_we_q;
  logic                busy_q;
  logic                frame_done_q;
  logic [7:0]          fb_data_q;
  logic [1:0]          err_q;

  logic [31:0] contrib_d;
  logic [32:0] add_d;
  logic [31:0] sum_d;
  logic        last_px_d;

  // Balls that never completed before a timeout are masked out via the vld snapshot.
  always_comb begin
    contrib_d = vld_q[idx_q] ? ball_out[32*idx_q +: 32] : 32'h0;
    add_d     = {1'b0, sum_q} + {1'b0, contrib_d};
    sum_d     = add_d[32] ? 32'hFFFF_FFFF : add_d[31:0];
    last_px_d = (px_q == XW'(DISP_W - 1)) && (py_q == YW'(DISP_H - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      px_q         <= '0;
      py_q         <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      vld_q        <= '0;
      pending_q    <= 1'b0;
      mov_en_q     <= 1'b0;
      px_stb_q     <= 1'b0;
      fb_we_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      fb_data_q    <= '0;
      err_q        <= '0;
    end else begin
      mov_en_q     <= 1'b0;
      px_stb_q     <= 1'b0;
      frame_done_q <= 1'b0;

      // Only one request can be queued behind the running frame.
      if (frame_tick && state_q != S_IDLE) begin
        if (!pending_q) pending_q <= 1'b1;
        else            err_q[1]  <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (frame_tick || pending_q) begin
            pending_q <= 1'b0;
            mov_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_MOVE;
          end
        end
        S_MOVE: begin
          px_q     <= '0;
          py_q     <= '0;
          addr_q   <= '0;
          px_stb_q <= 1'b1;
          state_q  <= S_STROBE;
        end
        S_STROBE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // cnt_q == 0 is the first WAIT cycle, where stale vld may still be high.
          if (cnt_q != '0 && &ball_vld) begin
            vld_q   <= ball_vld;
            idx_q   <= '0;
            state_q <= S_ACCUM;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q[0] <= 1'b1;
            vld_q    <= ball_vld;
            idx_q    <= '0;
            state_q  <= S_ACCUM;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_ACCUM: begin
          sum_q <= sum_d;
          idx_q <= idx_q + IW'(1);
          if (idx_q == IW'(N_BALLS - 1)) begin
            fb_we_q   <= 1'b1;
            fb_data_q <= (sum_d >= THRESH) ? 8'hFF : sum_d[15:8];
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (fb_ready) begin
            fb_we_q <= 1'b0;
            sum_q   <= '0;
            if (last_px_d) begin
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              if (px_q == XW'(DISP_W - 1)) begin
                px_q <= '0;
                py_q <= py_q + YW'(1);
              end else begin
                px_q <= px_q + XW'(1);
              end
              addr_q   <= addr_q + ADDR_W'(1);
              px_stb_q <= 1'b1;
              state_q  <= S_STROBE;
            end
          end
        end
        S_DONE: begin
          px_q    <= '0;
          py_q    <= '0;
          addr_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mov_en     = mov_en_q;
  assign px_stb     = px_stb_q;
  assign p_x        = {{(16 - XW){1'b0}}, px_q, 16'h0000};
  assign p_y        = {{(16 - YW){1'b0}}, py_q, 16'h0000};
  assign fb_we      = fb_we_q;
  assign fb_addr    = addr_q;
  assign fb_data    = fb_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_metaball_scheduler.sv
// Bench for metaball_scheduler on a 4x2 display with two stub balls; writes are
// scoreboarded against a sum/clamp/threshold model and a wait-latency model.
module tb_metaball_scheduler;
  localparam int          NB = 2;
  localparam int          W  = 4;
  localparam int          H  = 2;
  localparam int          TO = 8;
  localparam logic [31:0] TH = 32'h0001_0000;
  localparam int          AW = $clog2(W*H);

  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, fb_ready = 1'b1;
  logic mov_en, px_stb, fb_we, busy, frame_done;
  logic [31:0] p_x, p_y;
  logic [NB-1:0] ball_vld;
  logic [32*NB-1:0] ball_out = '0;
  logic [AW-1:0] fb_addr;
  logic [7:0] fb_data;
  logic [1:0] err;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  metaball_scheduler #(.N_BALLS(NB), .DISP_W(W), .DISP_H(H), .THRESH(TH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .mov_en(mov_en), .p_x(p_x), .p_y(p_y),
    .px_stb(px_stb), .ball_vld(ball_vld), .ball_out(ball_out), .fb_we(fb_we),
    .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  // Stub balls: drop vld after px_stb, raise it ball_lat cycles after px_stb if enabled.
  int ball_lat [NB];
  logic [NB-1:0] ball_en = '1;
  int bcnt [NB];
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (rst) begin
        ball_vld[i] <= 1'b0; bcnt[i] <= 0;
      end else if (px_stb) begin
        ball_vld[i] <= 1'b0; bcnt[i] <= 1;
      end else if (bcnt[i] != 0) begin
        if (bcnt[i] + 1 == ball_lat[i]) begin
          ball_vld[i] <= ball_en[i]; bcnt[i] <= 0;
        end else bcnt[i] <= bcnt[i] + 1;
      end
    end
  end

  logic ready_hold = 1'b0, ready_rand = 1'b0;
  initial forever begin
    @(posedge clk); #2;
    fb_ready = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  typedef struct { int addr; int data; int lat; } wr_t;
  wr_t wq[$];
  int cyc = 0, n_mov = 0, n_stb = 0, n_done = 0, n_we = 0, last_stb = 0, cur_lat = 0;
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (mov_en) n_mov++;
    if (px_stb) begin n_stb++; last_stb = cyc; end
    if (fb_we) n_we++;
    if (fb_we && !prev_we) cur_lat = cyc - last_stb;
    if (fb_we && fb_ready) wq.push_back('{int'(fb_addr), int'(fb_data), cur_lat});
    if (frame_done) n_done++;
    prev_we = fb_we;
  end

  logic [31:0] vals [NB];

  function automatic int exp_px();
    longint s = 0;
    for (int i = 0; i < NB; i++) if (ball_en[i]) s += {32'h0, vals[i]};
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    if (s >= TH) return 255;
    return int'((s >> 8) % 256);
  endfunction

  function automatic int exp_lat();
    int m = 2;
    for (int i = 0; i < NB; i++) if (ball_lat[i] > m) m = ball_lat[i];
    if (ball_en != '1) m = TO;
    return m + NB + 1;
  endfunction

  task automatic load_balls();
    for (int i = 0; i < NB; i++) ball_out[32*i +: 32] = vals[i];
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if ({mov_en, px_stb, fb_we, busy, frame_done} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {mov_en, px_stb, fb_we, busy, frame_done}); end
    checks++; if (p_x !== 32'h0 || p_y !== 32'h0) begin
      failures++; $display("FAIL reset_pxy got=%h/%h exp=0/0", p_x, p_y); end
    checks++; if (fb_addr !== '0 || fb_data !== 8'h0) begin
      failures++; $display("FAIL reset_fb got=%h/%h exp=0/0", fb_addr, fb_data); end
    checks++; if (err !== 2'b00) begin
      failures++; $display("FAIL reset_err got=%b exp=00", err); end
  endtask

  task automatic test_threshold();
    logic [31:0] pat [3];
    int expd [3];
    int m0, s0, d0, q0;
    bit ok;
    pat[0] = 32'h0000_8000; pat[1] = 32'h0000_2000; pat[2] = 32'hFFFF_0000;
    expd[0] = 255; expd[1] = 8'h40; expd[2] = 255;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NB; i++) begin vals[i] = pat[p]; ball_lat[i] = 3; end
      ball_en = '1; ready_rand = 1'b0; load_balls();
      m0 = n_mov; s0 = n_stb; d0 = n_done; q0 = wq.size();
      pulse_tick(); wait_done(400, ok); @(negedge clk);
      checks++; if (!ok) begin failures++; $display("FAIL thr_done pat=%0d got=timeout exp=frame_done", p); end
      checks++; if (n_mov - m0 != 1) begin failures++; $display("FAIL thr_mov got=%0d exp=1", n_mov - m0); end
      checks++; if (n_stb - s0 != 8) begin failures++; $display("FAIL thr_stb got=%0d exp=8", n_stb - s0); end
      checks++; if (n_done - d0 != 1) begin failures++; $display("FAIL thr_fdone got=%0d exp=1", n_done - d0); end
      checks++; if (wq.size() - q0 != 8) begin failures++; $display("FAIL thr_nwr got=%0d exp=8", wq.size() - q0); end
      for (int k = 0; k < 8 && q0 + k < wq.size(); k++) begin
        checks++; if (wq[q0+k].addr != k) begin failures++; $display("FAIL thr_addr got=%0d exp=%0d", wq[q0+k].addr, k); end
        checks++; if (wq[q0+k].data != expd[p]) begin failures++; $display("FAIL thr_data pat=%0d got=%h exp=%h", p, wq[q0+k].data, expd[p]); end
        checks++; if (wq[q0+k].lat != 6) begin failures++; $display("FAIL thr_lat got=%0d exp=6", wq[q0+k].lat); end
      end
      checks++; if (err !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL thr_idle got=err%b/busy%b exp=00/0", err, busy); end
    end
  endtask

  task automatic test_random();
    int q0, el, ed;
    bit ok;
    ready_rand = 1'b1; ball_en = '1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NB; i++) begin
        vals[i] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h9000);
        ball_lat[i] = $urandom_range(2, 6);
      end
      load_balls(); el = exp_lat(); ed = exp_px(); q0 = wq.size();
      pulse_tick(); wait_done(600, ok); @(negedge clk);
      checks++; if (!ok) begin failures++; $display("FAIL rnd_done frame=%0d got=timeout exp=frame_done", f); end
      checks++; if (wq.size() - q0 != 8) begin failures++; $display("FAIL rnd_nwr got=%0d exp=8", wq.size() - q0); end
      for (int k = 0; k < 8 && q0 + k < wq.size(); k++) begin
        checks++; if (wq[q0+k].addr != k || wq[q0+k].data != ed) begin failures++;
          $display("FAIL rnd_wr got=%0d:%h exp=%0d:%h vals=%h,%h", wq[q0+k].addr, wq[q0+k].data, k, ed, vals[0], vals[1]); end
        checks++; if (wq[q0+k].lat != el) begin failures++; $display("FAIL rnd_lat got=%0d exp=%0d", wq[q0+k].lat, el); end
      end
      checks++; if (err !== 2'b00) begin failures++; $display("FAIL rnd_err got=%b exp=00", err); end
    end
    ready_rand = 1'b0;
  endtask

  task automatic test_stall();
    int q0, k;
    bit ok;
    for (int i = 0; i < NB; i++) begin vals[i] = 32'h0000_2000; ball_lat[i] = 3; end
    ball_en = '1; load_balls(); q0 = wq.size();
    pulse_tick();
    k = 0;
    do begin @(negedge clk); k++; end while (!(px_stb && p_x == 32'h0003_0000 && p_y == 32'h0) && k < 400);
    checks++; if (k >= 400) begin failures++; $display("FAIL stall_find got=timeout exp=pixel3_stb"); end
    @(posedge clk); #1 ready_hold = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!fb_we && k < 100);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      checks++; if (fb_we !== 1'b1 || fb_addr !== AW'(3) || fb_data !== 8'h40 || px_stb !== 1'b0) begin failures++;
        $display("FAIL stall_hold cyc=%0d got=we%b/a%0d/d%h/stb%b exp=we1/a3/d40/stb0", j, fb_we, fb_addr, fb_data, px_stb); end
    end
    @(posedge clk); #1 ready_hold = 1'b0;
    wait_done(400, ok); @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL stall_done got=timeout exp=frame_done"); end
    checks++; if (wq.size() - q0 != 8) begin failures++; $display("FAIL stall_nwr got=%0d exp=8", wq.size() - q0); end
    for (int j = 0; j < 8 && q0 + j < wq.size(); j++) begin
      checks++; if (wq[q0+j].addr != j || wq[q0+j].data != 8'h40) begin failures++;
        $display("FAIL stall_wr got=%0d:%h exp=%0d:40", wq[q0+j].addr, wq[q0+j].data, j); end
    end
  endtask

  task automatic test_back_to_back();
    int m0, d0, q0, ed, k;
    bit ok;
    do_reset();
    for (int i = 0; i < NB; i++) begin vals[i] = $urandom_range(0, 32'h7000); ball_lat[i] = 3; end
    ball_en = '1; load_balls(); ed = exp_px();
    m0 = n_mov; d0 = n_done; q0 = wq.size();
    pulse_tick();
    repeat (5) @(posedge clk);
    pulse_tick();
    repeat (3) @(posedge clk);
    pulse_tick();
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done1 got=timeout exp=frame_done"); end
    k = 0;
    do begin @(negedge clk); k++; end while (!mov_en && k < 10);
    checks++; if (k != 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=2", k); end
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done2 got=timeout exp=frame_done"); end
    repeat (30) @(negedge clk);
    checks++; if (n_mov - m0 != 2) begin failures++; $display("FAIL b2b_mov got=%0d exp=2", n_mov - m0); end
    checks++; if (n_done - d0 != 2) begin failures++; $display("FAIL b2b_fdone got=%0d exp=2", n_done - d0); end
    checks++; if (wq.size() - q0 != 16) begin failures++; $display("FAIL b2b_nwr got=%0d exp=16", wq.size() - q0); end
    for (int j = 0; j < 16 && q0 + j < wq.size(); j++) begin
      checks++; if (wq[q0+j].addr != j % 8 || wq[q0+j].data != ed) begin failures++;
        $display("FAIL b2b_wr got=%0d:%h exp=%0d:%h", wq[q0+j].addr, wq[q0+j].data, j % 8, ed); end
    end
    checks++; if (err !== 2'b10 || busy !== 1'b0) begin failures++; $display("FAIL b2b_err got=err%b/busy%b exp=10/0", err, busy); end
  endtask

  task automatic test_timeout();
    int q0, ed, el;
    bit ok;
    do_reset();
    for (int i = 0; i < NB; i++) begin vals[i] = $urandom_range(32'h100, 32'hC000); ball_lat[i] = 3; end
    ball_en = 2'b01; load_balls(); ed = exp_px(); el = exp_lat(); q0 = wq.size();
    pulse_tick(); wait_done(600, ok); @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL to_done got=timeout exp=frame_done"); end
    checks++; if (err !== 2'b01) begin failures++; $display("FAIL to_err got=%b exp=01", err); end
    checks++; if (wq.size() - q0 != 8) begin failures++; $display("FAIL to_nwr got=%0d exp=8", wq.size() - q0); end
    for (int j = 0; j < 8 && q0 + j < wq.size(); j++) begin
      checks++; if (wq[q0+j].data != ed || wq[q0+j].lat != el) begin failures++;
        $display("FAIL to_wr got=%h/lat%0d exp=%h/lat%0d", wq[q0+j].data, wq[q0+j].lat, ed, el); end
    end
    ball_en = '1;
  endtask

  task automatic test_reset_mid();
    int w0, q0, k;
    do_reset();
    for (int i = 0; i < NB; i++) ball_lat[i] = 5;
    pulse_tick();
    k = 0;
    do begin @(negedge clk); k++; end while (!px_stb && k < 50);
    checks++; if (k >= 50) begin failures++; $display("FAIL rmid_stb got=timeout exp=px_stb"); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({mov_en, px_stb, fb_we, busy, frame_done, err} !== 7'b0 || p_x !== 32'h0 || p_y !== 32'h0 || fb_addr !== '0) begin
      failures++; $display("FAIL rmid_out got=%b/%h/%h/%0d exp=0", {mov_en, px_stb, fb_we, busy, frame_done, err}, p_x, p_y, fb_addr); end
    @(posedge clk); #1 rst = 1'b0;
    w0 = n_we; q0 = wq.size();
    repeat (60) @(negedge clk);
    checks++; if (n_we != w0 || wq.size() != q0 || busy !== 1'b0) begin failures++;
      $display("FAIL rmid_quiet got=we%0d/wr%0d/busy%b exp=0/0/0", n_we - w0, wq.size() - q0, busy); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NB; i++) begin ball_lat[i] = 3; vals[i] = 32'h0; end
    test_reset();
    test_threshold();
    test_random();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
